// File: rtl/regfile_mp_pkg.sv
// Shared constants, address-width helper and write-port bundle for regfile_mp.
// Include-free; imported by every regfile_mp file.
package regfile_mp_pkg;

  localparam int DATA_W_D = 32;
  localparam int NREGS_D  = 16;
  localparam int PC_IDX_D = 15;

  function automatic int addr_w(input int n);
    return $clog2(n);
  endfunction

  typedef struct packed {
    logic                         we;
    logic [addr_w(NREGS_D)-1:0]   wa;
    logic [DATA_W_D-1:0]          wd;
  } wr_port_t;

endpackage

// File: rtl/regfile_mp_rdport.sv
// One read port: storage mux, PC substitution and busy lookup.
// Same-cycle write forwarding is compiled in with `define REGFILE_MP_BYPASS_EN.
module regfile_mp_rdport
  import regfile_mp_pkg::*;
#(
  parameter int  DATA_W = DATA_W_D,
  parameter int  NREGS  = NREGS_D,
  parameter int  PC_IDX = PC_IDX_D,
  localparam int AW     = addr_w(NREGS)
) (
  input  logic [AW-1:0]     ra,
  input  logic [DATA_W-1:0] regs [NREGS],
  input  logic [NREGS-1:0]  busy,
  input  logic [DATA_W-1:0] pc_in,
  input  logic              we_a,
  input  logic [AW-1:0]     wa_a,
  input  logic [DATA_W-1:0] wd_a,
  input  logic              we_b,
  input  logic [AW-1:0]     wa_b,
  input  logic [DATA_W-1:0] wd_b,
  output logic [DATA_W-1:0] rd,
  output logic              rd_busy
);

  localparam logic [AW-1:0] PC_A = AW'(PC_IDX);

`ifdef REGFILE_MP_BYPASS_EN
  logic hit_a_s;
  logic hit_b_s;
  assign hit_a_s = we_a && (wa_a == ra);
  assign hit_b_s = we_b && (wa_b == ra);
`else
  logic unused_s;
  assign unused_s = ^{we_a, wa_a, wd_a, we_b, wa_b, wd_b};
`endif

  // Read mux: PC alias first, then forwarded write data, then storage.
  always_comb begin
    rd      = regs[ra];
    rd_busy = busy[ra];
    if (ra == PC_A) begin
      rd      = pc_in;
      rd_busy = 1'b0;
    end
`ifdef REGFILE_MP_BYPASS_EN
    else if (hit_a_s) begin
      rd      = wd_a;
      rd_busy = 1'b0;
    end else if (hit_b_s) begin
      rd      = wd_b;
      rd_busy = 1'b0;
    end
`endif
    else begin
      rd      = regs[ra];
      rd_busy = busy[ra];
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: two prioritised write ports, busy scoreboard, PC alias.
// Optional same-cycle forwarding: `define REGFILE_MP_BYPASS_EN.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int  DATA_W = DATA_W_D,
  parameter int  NREGS  = NREGS_D,
  parameter int  NRD    = 2,
  parameter int  PC_IDX = PC_IDX_D,
  localparam int AW     = addr_w(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NRD*AW-1:0]     ra,
  output logic [NRD*DATA_W-1:0] rd,
  output logic [NRD-1:0]        rd_busy,
  input  logic                  we_a,
  input  logic [AW-1:0]         wa_a,
  input  logic [DATA_W-1:0]     wd_a,
  input  logic                  we_b,
  input  logic [AW-1:0]         wa_b,
  input  logic [DATA_W-1:0]     wd_b,
  input  logic                  iss_valid,
  input  logic [AW-1:0]         iss_addr,
  input  logic [DATA_W-1:0]     pc_in,
  output logic                  wr_collision,
  output logic                  pc_wr_err
);

  localparam logic [AW-1:0] PC_A = AW'(PC_IDX);

  logic [DATA_W-1:0] regs_r [NREGS];
  logic [NREGS-1:0]  busy_r;
  logic [NREGS-1:0]  busy_nxt_s;
  logic              wr_collision_r;
  logic              pc_wr_err_r;

  logic wea_s;
  logic web_s;
  logic coll_s;
  logic pc_hit_s;

  // PC writes are dropped; port B yields to port A on an address clash.
  assign pc_hit_s = (we_a && (wa_a == PC_A)) || (we_b && (wa_b == PC_A));
  assign coll_s   = we_a && we_b && (wa_a == wa_b);
  assign wea_s    = we_a && (wa_a != PC_A);
  assign web_s    = we_b && (wa_b != PC_A) && !coll_s;

  // Scoreboard next state: a new issue overrides a same-cycle writeback clear.
  always_comb begin
    busy_nxt_s = busy_r;
    for (int i = 0; i < NREGS; i++) begin
      busy_nxt_s[i] = (iss_valid && (iss_addr == AW'(i)) && (iss_addr != PC_A)) ||
                      (busy_r[i] && !((wea_s && (wa_a == AW'(i))) ||
                                      (web_s && (wa_b == AW'(i)))));
    end
  end

  // Storage, scoreboard and error pulse registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= '0;
      end
      busy_r         <= '0;
      wr_collision_r <= 1'b0;
      pc_wr_err_r    <= 1'b0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (wea_s && (wa_a == AW'(i))) begin
          regs_r[i] <= wd_a;
        end else if (web_s && (wa_b == AW'(i))) begin
          regs_r[i] <= wd_b;
        end else begin
          regs_r[i] <= regs_r[i];
        end
      end
      busy_r         <= busy_nxt_s;
      wr_collision_r <= coll_s;
      pc_wr_err_r    <= pc_hit_s;
    end
  end

  assign wr_collision = wr_collision_r;
  assign pc_wr_err    = pc_wr_err_r;

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    regfile_mp_rdport #(
      .DATA_W (DATA_W),
      .NREGS  (NREGS),
      .PC_IDX (PC_IDX)
    ) u_rdport (
      .ra      (ra[g*AW +: AW]),
      .regs    (regs_r),
      .busy    (busy_r),
      .pc_in   (pc_in),
      .we_a    (we_a),
      .wa_a    (wa_a),
      .wd_a    (wd_a),
      .we_b    (we_b),
      .wa_b    (wa_b),
      .wd_b    (wd_b),
      .rd      (rd[g*DATA_W +: DATA_W]),
      .rd_busy (rd_busy[g])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios plus randomized traffic
// against an array-based reference model.
module tb_regfile_mp;

  logic        clk;
  logic        rst_n;
  logic [7:0]  ra;
  logic [63:0] rd;
  logic [1:0]  rd_busy;
  logic        we_a, we_b, iss_valid;
  logic [3:0]  wa_a, wa_b, iss_addr;
  logic [31:0] wd_a, wd_b, pc_in;
  logic        wr_collision, pc_wr_err;

  int ntests = 0;
  int nfail  = 0;

  logic [31:0] mregs [16];
  logic        mbusy [16];
  logic        mcoll, mpcerr;

  regfile_mp dut (
    .clk(clk), .rst_n(rst_n), .ra(ra), .rd(rd), .rd_busy(rd_busy),
    .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a),
    .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b),
    .iss_valid(iss_valid), .iss_addr(iss_addr), .pc_in(pc_in),
    .wr_collision(wr_collision), .pc_wr_err(pc_wr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference read value: PC alias, optional forwarding, else architectural state.
  function automatic logic [31:0] exp_rd(input logic [3:0] a);
    if (a == 4'd15) return pc_in;
`ifdef REGFILE_MP_BYPASS_EN
    if (we_a && wa_a == a) return wd_a;
    if (we_b && wa_b == a) return wd_b;
`endif
    return mregs[a];
  endfunction

  function automatic logic exp_busy(input logic [3:0] a);
    if (a == 4'd15) return 1'b0;
`ifdef REGFILE_MP_BYPASS_EN
    if ((we_a && wa_a == a) || (we_b && wa_b == a)) return 1'b0;
`endif
    return mbusy[a];
  endfunction

  // Advance one clock, applying the architectural rules to the model.
  task automatic step();
    @(posedge clk);
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin mregs[i] = 32'd0; mbusy[i] = 1'b0; end
      mcoll = 1'b0; mpcerr = 1'b0;
    end else begin
      mcoll  = we_a && we_b && (wa_a == wa_b);
      mpcerr = (we_a && wa_a == 4'd15) || (we_b && wa_b == 4'd15);
      if (we_b && wa_b != 4'd15) begin mregs[wa_b] = wd_b; mbusy[wa_b] = 1'b0; end
      if (we_a && wa_a != 4'd15) begin mregs[wa_a] = wd_a; mbusy[wa_a] = 1'b0; end
      if (iss_valid && iss_addr != 4'd15) mbusy[iss_addr] = 1'b1;
    end
    #1;
  endtask

  task automatic idle();
    we_a = 1'b0; we_b = 1'b0; iss_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; idle(); ra = 8'h00; pc_in = 32'h0;
    wa_a = 4'd0; wa_b = 4'd0; wd_a = 32'd0; wd_b = 32'd0; iss_addr = 4'd0;
    step(); step();
    rst_n = 1'b1; ra = {4'd15, 4'd3}; pc_in = 32'h0000_0100; #1;
    ntests++; if (rd[31:0] !== 32'd0) begin nfail++; $display("FAIL reset_rd0 got %h want %h", rd[31:0], 32'd0); end
    ntests++; if (rd[63:32] !== 32'h0000_0100) begin nfail++; $display("FAIL reset_pc got %h want %h", rd[63:32], 32'h100); end
    ntests++; if (rd_busy !== 2'b00) begin nfail++; $display("FAIL reset_busy got %b want 00", rd_busy); end
    ntests++; if (wr_collision !== 1'b0 || pc_wr_err !== 1'b0) begin nfail++; $display("FAIL reset_flags got %b%b want 00", wr_collision, pc_wr_err); end
  endtask

  task automatic test_basic_write();
    we_a = 1'b1; wa_a = 4'd3; wd_a = 32'h1234_5678;
    step(); idle(); ra = {4'd0, 4'd3}; #1;
    ntests++; if (rd[31:0] !== 32'h1234_5678) begin nfail++; $display("FAIL write_rd0 got %h want %h", rd[31:0], 32'h1234_5678); end
    ntests++; if (rd[63:32] !== 32'd0) begin nfail++; $display("FAIL write_rd1 got %h want 0", rd[63:32]); end
  endtask

  task automatic test_collision();
    we_a = 1'b1; we_b = 1'b1; wa_a = 4'd5; wa_b = 4'd5;
    wd_a = 32'hAAAA_AAAA; wd_b = 32'hBBBB_BBBB;
    step(); idle(); ra = {4'd5, 4'd5}; #1;
    ntests++; if (rd[31:0] !== 32'hAAAA_AAAA) begin nfail++; $display("FAIL coll_data got %h want %h", rd[31:0], 32'hAAAA_AAAA); end
    ntests++; if (rd[63:32] !== rd[31:0]) begin nfail++; $display("FAIL coll_ports got %h want %h", rd[63:32], rd[31:0]); end
    ntests++; if (wr_collision !== 1'b1) begin nfail++; $display("FAIL coll_pulse got %b want 1", wr_collision); end
    step();
    ntests++; if (wr_collision !== 1'b0) begin nfail++; $display("FAIL coll_one_cycle got %b want 0", wr_collision); end
  endtask

  task automatic test_scoreboard();
    ra = {4'd0, 4'd7}; iss_valid = 1'b1; iss_addr = 4'd7;
    step(); idle(); #1;
    ntests++; if (rd_busy[0] !== 1'b1) begin nfail++; $display("FAIL sb_set got %b want 1", rd_busy[0]); end
    we_b = 1'b1; wa_b = 4'd7; wd_b = 32'h0000_0777;
    step(); idle(); #1;
    ntests++; if (rd_busy[0] !== 1'b0) begin nfail++; $display("FAIL sb_clear got %b want 0", rd_busy[0]); end
    iss_valid = 1'b1; iss_addr = 4'd7; we_a = 1'b1; wa_a = 4'd7; wd_a = 32'h0000_0007;
    step(); idle(); #1;
    ntests++; if (rd_busy[0] !== 1'b1) begin nfail++; $display("FAIL sb_override got %b want 1", rd_busy[0]); end
    ntests++; if (rd[31:0] !== 32'h0000_0007) begin nfail++; $display("FAIL sb_data got %h want 7", rd[31:0]); end
    we_a = 1'b1; wa_a = 4'd7; wd_a = 32'h0000_0008;
    step(); idle();
  endtask

  task automatic test_pc();
    we_a = 1'b1; wa_a = 4'd15; wd_a = 32'hDEAD_BEEF;
    step(); idle(); pc_in = 32'hCAFE_0004; ra = {4'd15, 4'd15}; #1;
    ntests++; if (pc_wr_err !== 1'b1) begin nfail++; $display("FAIL pc_err got %b want 1", pc_wr_err); end
    ntests++; if (rd[31:0] !== 32'hCAFE_0004) begin nfail++; $display("FAIL pc_read got %h want %h", rd[31:0], 32'hCAFE_0004); end
    iss_valid = 1'b1; iss_addr = 4'd15;
    step(); idle(); #1;
    ntests++; if (pc_wr_err !== 1'b0) begin nfail++; $display("FAIL pc_err_clear got %b want 0", pc_wr_err); end
    ntests++; if (rd_busy !== 2'b00) begin nfail++; $display("FAIL pc_busy got %b want 00", rd_busy); end
  endtask

  task automatic test_bypass();
    logic [31:0] want;
    we_b = 1'b1; wa_b = 4'd2; wd_b = 32'h0000_0011;
    step(); idle();
    we_a = 1'b1; wa_a = 4'd2; wd_a = 32'h0000_0042; ra = {4'd15, 4'd2}; #1;
`ifdef REGFILE_MP_BYPASS_EN
    want = 32'h0000_0042;
`else
    want = 32'h0000_0011;
`endif
    ntests++; if (rd[31:0] !== want) begin nfail++; $display("FAIL bypass got %h want %h", rd[31:0], want); end
    step(); idle(); #1;
    ntests++; if (rd[31:0] !== 32'h0000_0042) begin nfail++; $display("FAIL bypass_after got %h want 42", rd[31:0]); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      we_a = 1'($urandom_range(0, 1)); we_b = 1'($urandom_range(0, 1));
      iss_valid = 1'($urandom_range(0, 1));
      wa_a = ($urandom_range(0, 4) == 0) ? 4'd15 : 4'($urandom_range(0, 7));
      wa_b = ($urandom_range(0, 4) == 0) ? 4'd15 : 4'($urandom_range(0, 7));
      iss_addr = ($urandom_range(0, 6) == 0) ? 4'd15 : 4'($urandom_range(0, 7));
      wd_a = $urandom; wd_b = $urandom; pc_in = $urandom;
      ra = {(($urandom_range(0, 5) == 0) ? 4'd15 : 4'($urandom_range(0, 7))), 4'($urandom_range(0, 7))};
      #1;
      ntests++;
      if (rd !== {exp_rd(ra[7:4]), exp_rd(ra[3:0])} ||
          rd_busy !== {exp_busy(ra[7:4]), exp_busy(ra[3:0])} ||
          wr_collision !== mcoll || pc_wr_err !== mpcerr) begin
        nfail++;
        $display("FAIL rand_%0d got rd=%h busy=%b c=%b p=%b want rd=%h busy=%b c=%b p=%b",
                 n, rd, rd_busy, wr_collision, pc_wr_err,
                 {exp_rd(ra[7:4]), exp_rd(ra[3:0])}, {exp_busy(ra[7:4]), exp_busy(ra[3:0])}, mcoll, mpcerr);
      end
      step();
    end
    idle();
  endtask

  task automatic test_reset_mid();
    iss_valid = 1'b1; iss_addr = 4'd4;
    step(); idle(); ra = {4'd6, 4'd4}; #1;
    ntests++; if (rd_busy[0] !== 1'b1) begin nfail++; $display("FAIL mid_pre_busy got %b want 1", rd_busy[0]); end
    rst_n = 1'b0; we_a = 1'b1; wa_a = 4'd6; wd_a = 32'h5555_5555;
    we_b = 1'b1; wa_b = 4'd6; wd_b = 32'h6666_6666; iss_valid = 1'b1; iss_addr = 4'd6;
    step(); rst_n = 1'b1; idle(); #1;
    ntests++; if (rd !== 64'd0) begin nfail++; $display("FAIL mid_rd got %h want 0", rd); end
    ntests++; if (rd_busy !== 2'b00) begin nfail++; $display("FAIL mid_busy got %b want 00", rd_busy); end
    ntests++; if (wr_collision !== 1'b0 || pc_wr_err !== 1'b0) begin nfail++; $display("FAIL mid_flags got %b%b want 00", wr_collision, pc_wr_err); end
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_collision();
    test_scoreboard();
    test_pc();
    test_bypass();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
